// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle for the multi-port register file.
//
// Groups the read ports, write ports and the scoreboard-set port. clk/rst_n stay plain ports on
// the register file itself.
//   raddr   : NUM_RD read addresses, port i at [i*AW +: AW]
//   rdata   : NUM_RD read data words, port i at [i*DW +: DW]
//   rbusy   : scoreboard busy bit per read port
//   wena    : per write port enable
//   waddr   : NUM_WR write addresses
//   wdata   : NUM_WR write data words
//   sb_set  : mark sb_addr as having a pending producer
//   sb_addr : scoreboard set address
//   par_err : per read port parity error (only when REGFILE_PARITY_EN is defined)
//
// Modports: master = decode/writeback side driving the file, slave = the register file.
interface regfile_mp_if #(
    parameter int unsigned ADDRESS_WIDTH = 6,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned NUM_RD        = 2,
    parameter int unsigned NUM_WR        = 2
);
    logic [NUM_RD*ADDRESS_WIDTH-1:0] raddr;
    logic [NUM_RD*DATA_WIDTH-1:0]    rdata;
    logic [NUM_RD-1:0]               rbusy;
    logic [NUM_WR-1:0]               wena;
    logic [NUM_WR*ADDRESS_WIDTH-1:0] waddr;
    logic [NUM_WR*DATA_WIDTH-1:0]    wdata;
    logic                            sb_set;
    logic [ADDRESS_WIDTH-1:0]        sb_addr;
`ifdef REGFILE_PARITY_EN
    logic [NUM_RD-1:0]               par_err;
`endif

    modport master (
        output raddr,
        output wena,
        output waddr,
        output wdata,
        output sb_set,
        output sb_addr,
`ifdef REGFILE_PARITY_EN
        input  par_err,
`endif
        input  rdata,
        input  rbusy
    );

    modport slave (
        input  raddr,
        input  wena,
        input  waddr,
        input  wdata,
        input  sb_set,
        input  sb_addr,
`ifdef REGFILE_PARITY_EN
        output par_err,
`endif
        output rdata,
        output rbusy
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with busy scoreboard.
//
// Register 0 is hardwired to zero (never written, never busy). Several write ports hitting the
// same address resolve to the highest port index. With BYPASS=1 a same-cycle write is forwarded
// to matching reads; with REGISTERED_OUTPUT=1 the read results are captured one cycle later.
// The busy scoreboard is set from decode (sb_set/sb_addr) and cleared by writeback writes; a set
// and clear on the same address in one cycle leaves the entry busy.
//
// Optional feature macro: REGFILE_PARITY_EN adds an even-parity bit per entry and the par_err
// output port on the bus interface.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears entries, busy bits and output registers
//   bus   : regfile_mp_if.slave (read/write/scoreboard ports, see the interface file)
module regfile_mp #(
    parameter int unsigned REGISTERED_OUTPUT = 0,
    parameter int unsigned ADDRESS_WIDTH     = 6,
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned NUM_RD            = 2,
    parameter int unsigned NUM_WR            = 2,
    parameter int unsigned BYPASS            = 1
) (
    input logic          clk,
    input logic          rst_n,
    regfile_mp_if.slave  bus
);
    localparam int unsigned Depth = 2 ** ADDRESS_WIDTH;

    // Unpacked views of the flat port vectors.
    logic [ADDRESS_WIDTH-1:0] raddr_a [NUM_RD];
    logic [ADDRESS_WIDTH-1:0] waddr_a [NUM_WR];
    logic [DATA_WIDTH-1:0]    wdata_a [NUM_WR];

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_unpack
        assign raddr_a[gi] = bus.raddr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    end

    for (genvar gp = 0; gp < NUM_WR; gp++) begin : g_wr_unpack
        assign waddr_a[gp] = bus.waddr[gp*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign wdata_a[gp] = bus.wdata[gp*DATA_WIDTH +: DATA_WIDTH];
    end

    // Storage and scoreboard state.
    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [DATA_WIDTH-1:0] mem_d [Depth];
    logic [Depth-1:0]      busy_q, busy_d;
`ifdef REGFILE_PARITY_EN
    logic [Depth-1:0]      par_q, par_d;
`endif

    // Write and scoreboard next state. Ascending port loop makes the highest port win; the set
    // is applied after all clears so it wins over a same-address clear.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
`ifdef REGFILE_PARITY_EN
        par_d  = par_q;
`endif
        for (int p = 0; p < NUM_WR; p++) begin
            if (bus.wena[p] && (waddr_a[p] != '0)) begin
                mem_d[waddr_a[p]]  = wdata_a[p];
                busy_d[waddr_a[p]] = 1'b0;
`ifdef REGFILE_PARITY_EN
                par_d[waddr_a[p]]  = ^wdata_a[p];
`endif
            end
        end
        if (bus.sb_set && (bus.sb_addr != '0)) begin
            busy_d[bus.sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < Depth; k++) begin
                mem_q[k] <= '0;
            end
            busy_q <= '0;
`ifdef REGFILE_PARITY_EN
            par_q  <= '0;
`endif
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
`ifdef REGFILE_PARITY_EN
            par_q  <= par_d;
`endif
        end
    end

    // Read path: stored value, optionally overridden by a same-cycle write, forced to zero for
    // address 0. A forwarded clearing write reports not-busy unless this cycle also re-sets it.
    logic [NUM_RD*DATA_WIDTH-1:0] rdata_d;
    logic [NUM_RD-1:0]            rbusy_d;
`ifdef REGFILE_PARITY_EN
    logic [NUM_RD-1:0]            par_err_d;
`endif

    always_comb begin
        rdata_d = '0;
        rbusy_d = '0;
`ifdef REGFILE_PARITY_EN
        par_err_d = '0;
`endif
        for (int i = 0; i < NUM_RD; i++) begin
            rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr_a[i]];
            rbusy_d[i] = busy_q[raddr_a[i]];
`ifdef REGFILE_PARITY_EN
            par_err_d[i] = (^mem_q[raddr_a[i]]) ^ par_q[raddr_a[i]];
`endif
            if (BYPASS != 0) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (bus.wena[p] && (waddr_a[p] == raddr_a[i])) begin
                        rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = wdata_a[p];
                        rbusy_d[i] = bus.sb_set && (bus.sb_addr == raddr_a[i]);
`ifdef REGFILE_PARITY_EN
                        par_err_d[i] = 1'b0;
`endif
                    end
                end
            end
            if (raddr_a[i] == '0) begin
                rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                rbusy_d[i] = 1'b0;
`ifdef REGFILE_PARITY_EN
                par_err_d[i] = 1'b0;
`endif
            end
        end
    end

    // Output stage: registered or pass-through.
    if (REGISTERED_OUTPUT != 0) begin : g_reg_out
        logic [NUM_RD*DATA_WIDTH-1:0] rdata_q;
        logic [NUM_RD-1:0]            rbusy_q;
`ifdef REGFILE_PARITY_EN
        logic [NUM_RD-1:0]            par_err_q;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q   <= '0;
                rbusy_q   <= '0;
`ifdef REGFILE_PARITY_EN
                par_err_q <= '0;
`endif
            end else begin
                rdata_q   <= rdata_d;
                rbusy_q   <= rbusy_d;
`ifdef REGFILE_PARITY_EN
                par_err_q <= par_err_d;
`endif
            end
        end

        assign bus.rdata   = rdata_q;
        assign bus.rbusy   = rbusy_q;
`ifdef REGFILE_PARITY_EN
        assign bus.par_err = par_err_q;
`endif
    end else begin : g_comb_out
        assign bus.rdata   = rdata_d;
        assign bus.rbusy   = rbusy_d;
`ifdef REGFILE_PARITY_EN
        assign bus.par_err = par_err_d;
`endif
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp.
//
// Three instances see identical stimulus: combinational with bypass (b), combinational without
// bypass (n) and registered output with bypass (r). Expected values are queued with the cycle
// at which they must be visible and compared when that cycle's outputs settle.
module tb_regfile_mp;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 64;
    localparam int unsigned NR = 2;
    localparam int unsigned NW = 2;

    // Observation selectors: instance base + signal offset.
    localparam int B  = 0;
    localparam int N  = 4;
    localparam int R  = 8;
    localparam int D0 = 0;
    localparam int D1 = 1;
    localparam int Y0 = 2;
    localparam int Y1 = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    regfile_mp_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) if_b ();
    regfile_mp_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) if_n ();
    regfile_mp_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) if_r ();

    regfile_mp #(
        .REGISTERED_OUTPUT(0), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    regfile_mp #(
        .REGISTERED_OUTPUT(0), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)
    ) dut_n (.clk(clk), .rst_n(rst_n), .bus(if_n));

    regfile_mp #(
        .REGISTERED_OUTPUT(1), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)
    ) dut_r (.clk(clk), .rst_n(rst_n), .bus(if_r));

    typedef struct {
        string       tag;
        int          due;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] obs(input int sel);
        case (sel)
            B + D0:  return if_b.rdata[63:0];
            B + D1:  return if_b.rdata[127:64];
            B + Y0:  return {63'd0, if_b.rbusy[0]};
            B + Y1:  return {63'd0, if_b.rbusy[1]};
            N + D0:  return if_n.rdata[63:0];
            N + D1:  return if_n.rdata[127:64];
            N + Y0:  return {63'd0, if_n.rbusy[0]};
            N + Y1:  return {63'd0, if_n.rbusy[1]};
            R + D0:  return if_r.rdata[63:0];
            R + D1:  return if_r.rdata[127:64];
            R + Y0:  return {63'd0, if_r.rbusy[0]};
            R + Y1:  return {63'd0, if_r.rbusy[1]};
            default: return 64'hx;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [63:0] val,
                            input int lat);
        exp_t e;
        e.tag = tag;
        e.due = cyc + lat;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check_due();
        int          i;
        logic [63:0] o;
        i = 0;
        while (i < sb_q.size()) begin
            if (sb_q[i].due == cyc) begin
                o = obs(sb_q[i].sel);
                checks++;
                assert (o === sb_q[i].val) else begin
                    errors++;
                    $error("FAIL %s observed=%h expected=%h", sb_q[i].tag, o, sb_q[i].val);
                end
                sb_q.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    // Compare at the negedge, then move to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        check_due();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                         input logic [NW-1:0] we,
                         input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                         input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                         input logic sbs, input logic [AW-1:0] sba);
        if_b.raddr = {ra1, ra0}; if_n.raddr = {ra1, ra0}; if_r.raddr = {ra1, ra0};
        if_b.wena  = we;         if_n.wena  = we;         if_r.wena  = we;
        if_b.waddr = {wa1, wa0}; if_n.waddr = {wa1, wa0}; if_r.waddr = {wa1, wa0};
        if_b.wdata = {wd1, wd0}; if_n.wdata = {wd1, wd0}; if_r.wdata = {wd1, wd0};
        if_b.sb_set  = sbs;      if_n.sb_set  = sbs;      if_r.sb_set  = sbs;
        if_b.sb_addr = sba;      if_n.sb_addr = sba;      if_r.sb_addr = sba;
    endtask

    localparam logic [63:0] V1 = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] V2 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] V3 = 64'hAABB_CCDD_EEFF_0011;
    localparam logic [63:0] VA = 64'hAAAA_AAAA_AAAA_AAAA;

    initial begin
        // Reset held across several edges.
        rst_n = 1'b0;
        drive(6'd5, 6'd63, 2'b00, 6'd0, 64'd0, 6'd0, 64'd0, 1'b0, 6'd0);
        push_exp("reset_r_d0", R + D0, 64'd0, 0);
        push_exp("reset_r_y0", R + Y0, 64'd0, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Read 5 and 63 after reset.
        drive(6'd5, 6'd63, 2'b00, 6'd0, 64'd0, 6'd0, 64'd0, 1'b0, 6'd0);
        push_exp("rst_b_d0", B + D0, 64'd0, 0);
        push_exp("rst_b_d1", B + D1, 64'd0, 0);
        push_exp("rst_b_y0", B + Y0, 64'd0, 0);
        push_exp("rst_b_y1", B + Y1, 64'd0, 0);
        push_exp("rst_r_d1", R + D1, 64'd0, 1);
        tick();

        // Dual write, then read back.
        drive(6'd5, 6'd63, 2'b11, 6'd1, V1, 6'd2, V2, 1'b0, 6'd0);
        tick();
        drive(6'd1, 6'd2, 2'b00, 6'd0, 64'd0, 6'd0, 64'd0, 1'b0, 6'd0);
        push_exp("wr_b_d0", B + D0, V1, 0);
        push_exp("wr_b_d1", B + D1, V2, 0);
        push_exp("wr_n_d1", N + D1, V2, 0);
        push_exp("wr_r_d0", R + D0, V1, 1);
        tick();

        // Same-address write conflict, then write to register 0.
        drive(6'd1, 6'd2, 2'b11, 6'd7, 64'h1111, 6'd7, 64'h2222, 1'b0, 6'd0);
        tick();
        drive(6'd7, 6'd0, 2'b01, 6'd0, 64'hDEAD_BEEF, 6'd0, 64'd0, 1'b0, 6'd0);
        push_exp("conf_b_d0", B + D0, 64'h2222, 0);
        push_exp("zero_b_d1", B + D1, 64'd0, 0);
        push_exp("zero_b_y1", B + Y1, 64'd0, 0);
        push_exp("conf_n_d0", N + D0, 64'h2222, 0);
        push_exp("zero_r_d1", R + D1, 64'd0, 1);
        tick();

        // Bypass versus no bypass.
        drive(6'd3, 6'd0, 2'b01, 6'd3, V3, 6'd0, 64'd0, 1'b0, 6'd0);
        push_exp("byp_b_d0", B + D0, V3, 0);
        push_exp("nobyp_n_d0", N + D0, 64'd0, 0);
        push_exp("byp_r_d0", R + D0, V3, 1);
        tick();
        drive(6'd3, 6'd0, 2'b00, 6'd0, 64'd0, 6'd0, 64'd0, 1'b0, 6'd0);
        push_exp("late_n_d0", N + D0, V3, 0);
        push_exp("zero_rd_b_d1", B + D1, 64'd0, 0);
        tick();

        // Scoreboard set, then observe busy.
        drive(6'd9, 6'd0, 2'b00, 6'd0, 64'd0, 6'd0, 64'd0, 1'b1, 6'd9);
        tick();
        drive(6'd9, 6'd0, 2'b00, 6'd0, 64'd0, 6'd0, 64'd0, 1'b0, 6'd0);
        push_exp("set_b_y0", B + Y0, 64'd1, 0);
        push_exp("set_n_y0", N + Y0, 64'd1, 0);
        push_exp("set_r_y0", R + Y0, 64'd1, 1);
        tick();

        // Clearing write on port 1.
        drive(6'd9, 6'd0, 2'b10, 6'd0, 64'd0, 6'd9, 64'h99, 1'b0, 6'd0);
        push_exp("clr_b_y0", B + Y0, 64'd0, 0);
        push_exp("clr_b_d0", B + D0, 64'h99, 0);
        push_exp("clr_n_y0", N + Y0, 64'd1, 0);
        push_exp("clr_n_d0", N + D0, 64'd0, 0);
        push_exp("clr_r_y0", R + Y0, 64'd0, 1);
        tick();
        drive(6'd9, 6'd0, 2'b00, 6'd0, 64'd0, 6'd0, 64'd0, 1'b0, 6'd0);
        push_exp("clr2_b_y0", B + Y0, 64'd0, 0);
        push_exp("clr2_n_y0", N + Y0, 64'd0, 0);
        push_exp("clr2_n_d0", N + D0, 64'h99, 0);
        tick();

        // Set and clear in one cycle: set wins.
        drive(6'd9, 6'd0, 2'b01, 6'd9, 64'h5, 6'd0, 64'd0, 1'b1, 6'd9);
        push_exp("both_b_y0", B + Y0, 64'd1, 0);
        push_exp("both_b_d0", B + D0, 64'h5, 0);
        push_exp("both_n_y0", N + Y0, 64'd0, 0);
        push_exp("both_r_y0", R + Y0, 64'd1, 1);
        tick();
        drive(6'd9, 6'd0, 2'b00, 6'd0, 64'd0, 6'd0, 64'd0, 1'b0, 6'd0);
        push_exp("both2_b_y0", B + Y0, 64'd1, 0);
        push_exp("both2_n_y0", N + Y0, 64'd1, 0);
        push_exp("both2_n_d0", N + D0, 64'h5, 0);
        tick();

        // Registered latency: raddr moves from 3 to 10.
        drive(6'd3, 6'd0, 2'b01, 6'd10, VA, 6'd0, 64'd0, 1'b0, 6'd0);
        push_exp("lat_r_old", R + D0, V3, 1);
        tick();
        drive(6'd10, 6'd0, 2'b00, 6'd0, 64'd0, 6'd0, 64'd0, 1'b1, 6'd10);
        push_exp("lat_b_d0", B + D0, VA, 0);
        push_exp("lat_r_new", R + D0, VA, 1);
        tick();
        drive(6'd10, 6'd0, 2'b00, 6'd0, 64'd0, 6'd0, 64'd0, 1'b0, 6'd0);
        push_exp("pre_b_y0", B + Y0, 64'd1, 0);
        tick();

        // Asynchronous reset mid-sequence, observed without an intervening clock edge.
        push_exp("pre_r_d0", R + D0, VA, 0);
        push_exp("pre_r_y0", R + Y0, 64'd1, 0);
        push_exp("pre2_b_y0", B + Y0, 64'd1, 0);
        check_due();
        rst_n = 1'b0;
        #1;
        push_exp("arst_r_d0", R + D0, 64'd0, 0);
        push_exp("arst_r_y0", R + Y0, 64'd0, 0);
        push_exp("arst_b_d0", B + D0, 64'd0, 0);
        push_exp("arst_b_y0", B + Y0, 64'd0, 0);
        check_due();

        checks++;
        assert (sb_q.size() === 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
